// File: rtl/spi_cmd_pkg.sv
// Shared types and constants for the SPI command front end.
package spi_cmd_pkg;

  typedef enum logic [2:0] {
    S_OPC,
    S_ADDR,
    S_WDATA,
    S_DUMMY,
    S_RDATA,
    S_DONE
  } spi_cmd_state_e;

  localparam logic [7:0]  OP_WR_DEF      = 8'h02;
  localparam logic [7:0]  OP_RD_DEF      = 8'h03;

  localparam int unsigned OPC_BITS       = 8;
  localparam int unsigned ADDR_W_DEF     = 8;
  localparam int unsigned DATA_W_DEF     = 32;
  localparam int unsigned DUMMY_BITS_DEF = 8;

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/spi_cmd_frontend.sv
// SPI-clock-domain command parser: opcode/address/data frames become write and
// read-request hand-offs (toggle + held bus) and read data is returned on MISO.
module spi_cmd_frontend
  import spi_cmd_pkg::*;
#(
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter logic [7:0]  OP_WR      = OP_WR_DEF,
  parameter logic [7:0]  OP_RD      = OP_RD_DEF,
  parameter int unsigned DUMMY_BITS = DUMMY_BITS_DEF
) (
  input  logic              i_sclk,
  input  logic              i_rst_n,
  input  logic              i_ss_n,
  input  logic              i_mosi,
  output logic              o_miso,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [DATA_W-1:0] o_wr_data,
  output logic              o_wr_tgl,
  output logic [ADDR_W-1:0] o_rd_addr,
  output logic              o_rd_tgl,
  input  logic [DATA_W-1:0] i_rd_data,
  output logic [7:0]        o_bad_op_cnt
);

  localparam int unsigned RX_W   = max2(OPC_BITS, max2(ADDR_W, DATA_W));
  localparam int unsigned MAXLEN = max2(max2(OPC_BITS, DUMMY_BITS), max2(ADDR_W, DATA_W));
  localparam int unsigned CNT_W  = $clog2(MAXLEN);

  logic                 w_frm_rst_n;
  spi_cmd_state_e       r_state;
  spi_cmd_state_e       w_state_nxt;
  logic [CNT_W-1:0]     r_cnt;
  logic [RX_W-2:0]      r_rx;
  logic [RX_W-1:0]      w_rx_nxt;
  logic [DATA_W-1:0]    r_tx;
  logic [ADDR_W-1:0]    r_addr;
  logic                 r_is_rd;
  logic                 w_is_rd_nxt;
  logic                 w_phase_end;
  logic                 w_wr_done;
  logic                 w_rd_req;
  logic                 w_bad_op;
  logic                 w_load_tx;
  logic                 r_miso;
  logic [ADDR_W-1:0]    r_wr_addr;
  logic [DATA_W-1:0]    r_wr_data;
  logic                 r_wr_tgl;
  logic [ADDR_W-1:0]    r_rd_addr;
  logic                 r_rd_tgl;
  logic [7:0]           r_bad_op_cnt;

  // Deasserting chip select restarts the frame parser without touching the hand-off registers.
  assign w_frm_rst_n = i_rst_n & ~i_ss_n;
  assign w_rx_nxt    = {r_rx, i_mosi};

  always_ff @(posedge i_sclk or negedge w_frm_rst_n) begin
    if (!w_frm_rst_n) r_state <= S_OPC;
    else              r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_is_rd_nxt = r_is_rd;
    w_phase_end = 1'b0;
    w_wr_done   = 1'b0;
    w_rd_req    = 1'b0;
    w_bad_op    = 1'b0;
    w_load_tx   = 1'b0;
    unique case (r_state)
      S_OPC: begin
        if (r_cnt == CNT_W'(OPC_BITS - 1)) begin
          w_phase_end = 1'b1;
          if (w_rx_nxt[7:0] == OP_WR) begin
            w_state_nxt = S_ADDR;
            w_is_rd_nxt = 1'b0;
          end else if (w_rx_nxt[7:0] == OP_RD) begin
            w_state_nxt = S_ADDR;
            w_is_rd_nxt = 1'b1;
          end else begin
            w_state_nxt = S_DONE;
            w_bad_op    = 1'b1;
          end
        end
      end
      S_ADDR: begin
        if (r_cnt == CNT_W'(ADDR_W - 1)) begin
          w_phase_end = 1'b1;
          if (r_is_rd) begin
            w_state_nxt = S_DUMMY;
            w_rd_req    = 1'b1;
          end else begin
            w_state_nxt = S_WDATA;
          end
        end
      end
      S_WDATA: begin
        if (r_cnt == CNT_W'(DATA_W - 1)) begin
          w_phase_end = 1'b1;
          w_wr_done   = 1'b1;
          w_state_nxt = S_DONE;
        end
      end
      S_DUMMY: begin
        if (r_cnt == CNT_W'(DUMMY_BITS - 1)) begin
          w_phase_end = 1'b1;
          w_load_tx   = 1'b1;
          w_state_nxt = S_RDATA;
        end
      end
      S_RDATA: begin
        if (r_cnt == CNT_W'(DATA_W - 1)) begin
          w_phase_end = 1'b1;
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_DONE;
      end
      default: begin
        w_state_nxt = S_DONE;
      end
    endcase
  end

  always_ff @(posedge i_sclk or negedge w_frm_rst_n) begin
    if (!w_frm_rst_n) begin
      r_cnt   <= '0;
      r_rx    <= '0;
      r_tx    <= '0;
      r_addr  <= '0;
      r_is_rd <= 1'b0;
    end else begin
      r_is_rd <= w_is_rd_nxt;
      if (r_state != S_DONE) begin
        r_rx  <= w_rx_nxt[RX_W-2:0];
        r_cnt <= w_phase_end ? '0 : r_cnt + 1'b1;
      end
      if ((r_state == S_ADDR) && w_phase_end) r_addr <= w_rx_nxt[ADDR_W-1:0];
      if (w_load_tx)                  r_tx <= i_rd_data;
      else if (r_state == S_RDATA)    r_tx <= {r_tx[DATA_W-2:0], 1'b0};
    end
  end

  // MISO launches on the falling edge so the master's rising-edge sample sees a settled bit.
  always_ff @(negedge i_sclk or negedge w_frm_rst_n) begin
    if (!w_frm_rst_n)             r_miso <= 1'b0;
    else if (r_state == S_RDATA)  r_miso <= r_tx[DATA_W-1];
    else                          r_miso <= 1'b0;
  end

  always_ff @(posedge i_sclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_wr_tgl     <= 1'b0;
      r_rd_addr    <= '0;
      r_rd_tgl     <= 1'b0;
      r_bad_op_cnt <= '0;
    end else begin
      if (w_wr_done) begin
        r_wr_addr <= r_addr;
        r_wr_data <= w_rx_nxt[DATA_W-1:0];
        r_wr_tgl  <= ~r_wr_tgl;
      end
      if (w_rd_req) begin
        r_rd_addr <= w_rx_nxt[ADDR_W-1:0];
        r_rd_tgl  <= ~r_rd_tgl;
      end
      if (w_bad_op && (r_bad_op_cnt != 8'hFF)) r_bad_op_cnt <= r_bad_op_cnt + 8'd1;
    end
  end

  assign o_miso       = r_miso;
  assign o_wr_addr    = r_wr_addr;
  assign o_wr_data    = r_wr_data;
  assign o_wr_tgl     = r_wr_tgl;
  assign o_rd_addr    = r_rd_addr;
  assign o_rd_tgl     = r_rd_tgl;
  assign o_bad_op_cnt = r_bad_op_cnt;

endmodule

// File: tb/tb_spi_cmd_frontend.sv
// Bench for spi_cmd_frontend: table of frames plus hand-written saturation and reset sequences.
module tb_spi_cmd_frontend;

  logic        sclk  = 1'b0;
  logic        rst_n = 1'b0;
  logic        ss_n  = 1'b1;
  logic        mosi  = 1'b0;
  logic        miso;
  logic [7:0]  wr_addr;
  logic [31:0] wr_data;
  logic        wr_tgl;
  logic [7:0]  rd_addr;
  logic        rd_tgl;
  logic [31:0] rd_data = '0;
  logic [7:0]  bad_cnt;

  spi_cmd_frontend #(
    .ADDR_W(8), .DATA_W(32), .OP_WR(8'h02), .OP_RD(8'h03), .DUMMY_BITS(8)
  ) dut (
    .i_sclk(sclk), .i_rst_n(rst_n), .i_ss_n(ss_n), .i_mosi(mosi), .o_miso(miso),
    .o_wr_addr(wr_addr), .o_wr_data(wr_data), .o_wr_tgl(wr_tgl),
    .o_rd_addr(rd_addr), .o_rd_tgl(rd_tgl), .i_rd_data(rd_data), .o_bad_op_cnt(bad_cnt)
  );

  typedef struct {
    string       name;
    logic [7:0]  op;
    logic [7:0]  addr;
    logic [31:0] data;
    logic [31:0] rdd;
    int          nbits;
    bit          loop_rd;
    bit          exp_wr;
    bit          exp_rd;
    bit          exp_bad;
    logic [31:0] exp_miso;
  } vec_t;

  int n_checks = 0;
  int n_pass   = 0;

  logic [39:0] wr_q[$];
  logic [7:0]  rd_q[$];

  logic miso_at[1:80];
  logic wr_at[1:80];
  logic rd_at[1:80];

  logic        m_wr_tgl, m_rd_tgl;
  logic [7:0]  m_wr_addr, m_rd_addr, m_bad;
  logic [31:0] m_wr_data;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  always @(wr_tgl) begin
    #1;
    if (rst_n) begin
      if (wr_q.size() == 0) check("wr_unexpected_toggle", 64'd1, 64'd0);
      else begin
        logic [39:0] e;
        e = wr_q.pop_front();
        check("sb_wr_addr", {56'd0, wr_addr}, {56'd0, e[39:32]});
        check("sb_wr_data", {32'd0, wr_data}, {32'd0, e[31:0]});
      end
    end
  end

  always @(rd_tgl) begin
    #1;
    if (rst_n) begin
      if (rd_q.size() == 0) check("rd_unexpected_toggle", 64'd1, 64'd0);
      else begin
        logic [7:0] e;
        e = rd_q.pop_front();
        check("sb_rd_addr", {56'd0, rd_addr}, {56'd0, e});
      end
    end
  end

  task automatic send_bit(input logic b, input int k);
    mosi = b;
    #4;
    miso_at[k] = miso;
    sclk = 1'b1;
    #2;
    wr_at[k] = wr_tgl;
    rd_at[k] = rd_tgl;
    #3;
    sclk = 1'b0;
    #1;
  endtask

  task automatic run_frame(input logic [79:0] bits, input int n);
    ss_n = 1'b0;
    #5;
    for (int i = 0; i < n; i++) send_bit(bits[79-i], i + 1);
    #5;
    ss_n = 1'b1;
    #5;
  endtask

  task automatic reset_model();
    m_wr_tgl = 1'b0; m_rd_tgl = 1'b0; m_wr_addr = '0; m_rd_addr = '0;
    m_wr_data = '0;  m_bad = '0;
  endtask

  task automatic apply_vec(input vec_t v);
    logic [79:0] bits;
    logic [31:0] word;
    logic        any;
    bits    = {v.op, v.addr, v.data, 32'h0};
    rd_data = v.loop_rd ? wr_data : v.rdd;
    if (v.exp_wr) wr_q.push_back({v.addr, v.data});
    if (v.exp_rd) rd_q.push_back(v.addr);
    run_frame(bits, v.nbits);
    if (v.exp_wr) begin
      check({v.name, "_wr_tgl_e47"}, {63'd0, wr_at[47]}, {63'd0, m_wr_tgl});
      check({v.name, "_wr_tgl_e48"}, {63'd0, wr_at[48]}, {63'd0, ~m_wr_tgl});
      m_wr_tgl = ~m_wr_tgl; m_wr_addr = v.addr; m_wr_data = v.data;
    end
    if (v.exp_rd) begin
      check({v.name, "_rd_tgl_e15"}, {63'd0, rd_at[15]}, {63'd0, m_rd_tgl});
      check({v.name, "_rd_tgl_e16"}, {63'd0, rd_at[16]}, {63'd0, ~m_rd_tgl});
      m_rd_tgl = ~m_rd_tgl; m_rd_addr = v.addr;
    end
    if (v.exp_bad && m_bad != 8'hFF) m_bad = m_bad + 8'd1;
    check({v.name, "_wr_tgl"},  {63'd0, wr_tgl},   {63'd0, m_wr_tgl});
    check({v.name, "_rd_tgl"},  {63'd0, rd_tgl},   {63'd0, m_rd_tgl});
    check({v.name, "_wr_bus"},  {24'd0, wr_addr, wr_data}, {24'd0, m_wr_addr, m_wr_data});
    check({v.name, "_rd_addr"}, {56'd0, rd_addr},  {56'd0, m_rd_addr});
    check({v.name, "_bad_cnt"}, {56'd0, bad_cnt},  {56'd0, m_bad});
    if (v.exp_rd && v.nbits >= 56) begin
      word = '0;
      for (int k = 25; k <= 56; k++) word = {word[30:0], miso_at[k]};
      check({v.name, "_miso_word"}, {32'd0, word}, {32'd0, v.exp_miso});
    end else begin
      any = 1'b0;
      for (int k = 1; k <= v.nbits; k++) any = any | miso_at[k];
      check({v.name, "_miso_idle"}, {63'd0, any}, 64'd0);
    end
  endtask

  function automatic vec_t mk(input string nm, input logic [7:0] op, input logic [7:0] a,
                              input logic [31:0] d, input logic [31:0] rdd, input int n,
                              input bit lp, input bit ew, input bit er, input bit eb,
                              input logic [31:0] em);
    vec_t v;
    v.name = nm; v.op = op; v.addr = a; v.data = d; v.rdd = rdd; v.nbits = n;
    v.loop_rd = lp; v.exp_wr = ew; v.exp_rd = er; v.exp_bad = eb; v.exp_miso = em;
    return v;
  endfunction

  initial begin
    vec_t vecs[8];
    vec_t bad_v;
    vecs[0] = mk("wr10",      8'h02, 8'h10, 32'hDEADBEEF, 32'h0,        48, 0, 1, 0, 0, 32'h0);
    vecs[1] = mk("rd20",      8'h03, 8'h20, 32'h0,        32'hA5C30F96, 56, 0, 0, 1, 0, 32'hA5C30F96);
    vecs[2] = mk("bad7f",     8'h7F, 8'h00, 32'h0,        32'h0,        48, 0, 0, 0, 1, 32'h0);
    vecs[3] = mk("wr_abort",  8'h02, 8'h55, 32'hFFFFFFFF, 32'h0,        30, 0, 0, 0, 0, 32'h0);
    vecs[4] = mk("wr05",      8'h02, 8'h05, 32'h12345678, 32'h0,        48, 0, 1, 0, 0, 32'h0);
    vecs[5] = mk("rd05_loop", 8'h03, 8'h05, 32'h0,        32'h0,        56, 1, 0, 1, 0, 32'h12345678);
    vecs[6] = mk("rd_trunc",  8'h03, 8'h77, 32'h0,        32'h0,        20, 0, 0, 1, 0, 32'h0);
    vecs[7] = mk("opc_trunc", 8'h03, 8'h66, 32'h0,        32'h0,         5, 0, 0, 0, 0, 32'h0);

    reset_model();
    #20;
    check("rst_miso",    {63'd0, miso},    64'd0);
    check("rst_wr_bus",  {24'd0, wr_addr, wr_data}, 64'd0);
    check("rst_wr_tgl",  {63'd0, wr_tgl},  64'd0);
    check("rst_rd_addr", {56'd0, rd_addr}, 64'd0);
    check("rst_rd_tgl",  {63'd0, rd_tgl},  64'd0);
    check("rst_bad_cnt", {56'd0, bad_cnt}, 64'd0);
    rst_n = 1'b1;
    #10;

    for (int i = 0; i < 8; i++) apply_vec(vecs[i]);

    // Unknown-opcode counter must stop at 255.
    bad_v = mk("bad_sat", 8'h7F, 8'hAA, 32'h55AA55AA, 32'h0, 48, 0, 0, 0, 1, 32'h0);
    for (int i = 0; i < 300; i++) begin
      run_frame({bad_v.op, bad_v.addr, bad_v.data, 32'h0}, 48);
      if (m_bad != 8'hFF) m_bad = m_bad + 8'd1;
    end
    check("sat_bad_cnt", {56'd0, bad_cnt}, 64'd255);
    check("sat_wr_tgl",  {63'd0, wr_tgl},  {63'd0, m_wr_tgl});
    check("sat_rd_tgl",  {63'd0, rd_tgl},  {63'd0, m_rd_tgl});

    // System reset in the middle of write data: nothing partial may appear.
    ss_n = 1'b0;
    #5;
    begin
      logic [79:0] bits;
      bits = {8'h02, 8'h44, 32'hABCDEF01, 32'h0};
      for (int i = 0; i < 36; i++) send_bit(bits[79-i], i + 1);
    end
    rst_n = 1'b0;
    #3;
    reset_model();
    check("midrst_miso",    {63'd0, miso},    64'd0);
    check("midrst_wr_bus",  {24'd0, wr_addr, wr_data}, 64'd0);
    check("midrst_wr_tgl",  {63'd0, wr_tgl},  64'd0);
    check("midrst_rd_addr", {56'd0, rd_addr}, 64'd0);
    check("midrst_rd_tgl",  {63'd0, rd_tgl},  64'd0);
    check("midrst_bad_cnt", {56'd0, bad_cnt}, 64'd0);
    #5;
    ss_n  = 1'b1;
    #5;
    rst_n = 1'b1;
    #10;
    apply_vec(mk("wr_after_rst", 8'h02, 8'h33, 32'hCAFEF00D, 32'h0, 48, 0, 1, 0, 0, 32'h0));

    #20;
    check("sb_wr_drained", {32'd0, wr_q.size()}, 64'd0);
    check("sb_rd_drained", {32'd0, rd_q.size()}, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
